// File: rtl/huffman_merge.sv
// rtl/huffman_merge.sv - merges six sorted leaf nodes into a Huffman tree, one record per merge
module huffman_merge (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        merge_begin,
    input  logic [12:0] new1,
    input  logic [12:0] new2,
    input  logic [12:0] new3,
    input  logic [12:0] new4,
    input  logic [12:0] new5,
    input  logic [12:0] new6,
    output logic        rec_valid,
    output logic [4:0]  rec_left,
    output logic [4:0]  rec_right,
    output logic [4:0]  rec_parent,
    output logic [7:0]  rec_weight,
    output logic [12:0] root,
    output logic        merge_over
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MERGE  = 2'd1;
    localparam logic [1:0] ST_INSERT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [12:0] list_q [6];
    logic [12:0] list_d [6];
    logic [2:0]  count_q, count_d;
    logic [4:0]  next_id_q, next_id_d;
    logic [12:0] temp_q, temp_d;
    logic        rec_valid_q, rec_valid_d;
    logic [4:0]  rec_left_q, rec_left_d;
    logic [4:0]  rec_right_q, rec_right_d;
    logic [4:0]  rec_parent_q, rec_parent_d;
    logic [7:0]  rec_weight_q, rec_weight_d;
    logic [12:0] root_q, root_d;
    logic        merge_over_q, merge_over_d;

    logic [8:0]  sum;
    logic [7:0]  sum_sat;
    logic [2:0]  pos;
    logic        found;

    // Next-state: capture, merge the two lightest nodes, then re-insert the parent in order
    always_comb begin
        state_d      = state_q;
        list_d       = list_q;
        count_d      = count_q;
        next_id_d    = next_id_q;
        temp_d       = temp_q;
        rec_valid_d  = rec_valid_q;
        rec_left_d   = rec_left_q;
        rec_right_d  = rec_right_q;
        rec_parent_d = rec_parent_q;
        rec_weight_d = rec_weight_q;
        root_d       = root_q;
        merge_over_d = merge_over_q;
        sum          = {1'b0, list_q[0][12:5]} + {1'b0, list_q[1][12:5]};
        sum_sat      = sum[8] ? 8'hFF : sum[7:0];
        pos          = count_q;
        found        = 1'b0;

        // First live entry at least as heavy as temp; ties place the new node first
        for (int i = 0; i < 6; i++) begin
            if (!found && (3'(i) < count_q) && (list_q[i][12:5] >= temp_q[12:5])) begin
                pos   = 3'(i);
                found = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (merge_begin) begin
                    list_d[0]    = new1;
                    list_d[1]    = new2;
                    list_d[2]    = new3;
                    list_d[3]    = new4;
                    list_d[4]    = new5;
                    list_d[5]    = new6;
                    count_d      = 3'd6;
                    next_id_d    = 5'd6;
                    merge_over_d = 1'b0;
                    state_d      = ST_MERGE;
                end
            end
            ST_MERGE: begin
                rec_valid_d  = 1'b1;
                rec_left_d   = list_q[0][4:0];
                rec_right_d  = list_q[1][4:0];
                rec_parent_d = next_id_q;
                rec_weight_d = sum_sat;
                temp_d       = {sum_sat, next_id_q};
                for (int i = 0; i < 4; i++) begin
                    list_d[i] = list_q[i+2];
                end
                list_d[4]    = 13'd0;
                list_d[5]    = 13'd0;
                count_d      = count_q - 3'd2;
                state_d      = ST_INSERT;
            end
            ST_INSERT: begin
                rec_valid_d = 1'b0;
                list_d[0]   = (pos == 3'd0) ? temp_q : list_q[0];
                for (int i = 1; i < 6; i++) begin
                    if (3'(i) < pos) begin
                        list_d[i] = list_q[i];
                    end else if (3'(i) == pos) begin
                        list_d[i] = temp_q;
                    end else begin
                        list_d[i] = list_q[i-1];
                    end
                end
                count_d   = count_q + 3'd1;
                next_id_d = next_id_q + 5'd1;
                if (count_d > 3'd1) begin
                    state_d = ST_MERGE;
                end else begin
                    root_d       = temp_q;
                    merge_over_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < 6; i++) begin
                list_q[i] <= 13'd0;
            end
            count_q      <= 3'd0;
            next_id_q    <= 5'd6;
            temp_q       <= 13'd0;
            rec_valid_q  <= 1'b0;
            rec_left_q   <= 5'd0;
            rec_right_q  <= 5'd0;
            rec_parent_q <= 5'd0;
            rec_weight_q <= 8'd0;
            root_q       <= 13'd0;
            merge_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            list_q       <= list_d;
            count_q      <= count_d;
            next_id_q    <= next_id_d;
            temp_q       <= temp_d;
            rec_valid_q  <= rec_valid_d;
            rec_left_q   <= rec_left_d;
            rec_right_q  <= rec_right_d;
            rec_parent_q <= rec_parent_d;
            rec_weight_q <= rec_weight_d;
            root_q       <= root_d;
            merge_over_q <= merge_over_d;
        end
    end

    assign rec_valid  = rec_valid_q;
    assign rec_left   = rec_left_q;
    assign rec_right  = rec_right_q;
    assign rec_parent = rec_parent_q;
    assign rec_weight = rec_weight_q;
    assign root       = root_q;
    assign merge_over = merge_over_q;

endmodule

// File: tb/tb_huffman_merge.sv
// tb/tb_huffman_merge.sv - table-driven bench for huffman_merge
module tb_huffman_merge;

    logic        clk;
    logic        nrst;
    logic        merge_begin;
    logic [12:0] new_v [6];
    logic        rec_valid;
    logic [4:0]  rec_left;
    logic [4:0]  rec_right;
    logic [4:0]  rec_parent;
    logic [7:0]  rec_weight;
    logic [12:0] root;
    logic        merge_over;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  w  [6];
        logic [4:0]  l  [5];
        logic [4:0]  r  [5];
        logic [4:0]  p  [5];
        logic [7:0]  rw [5];
        logic [12:0] root;
    } vec_t;

    vec_t tbl [3];

    huffman_merge dut (
        .CLK         (clk),
        .nRST        (nrst),
        .merge_begin (merge_begin),
        .new1        (new_v[0]),
        .new2        (new_v[1]),
        .new3        (new_v[2]),
        .new4        (new_v[3]),
        .new5        (new_v[4]),
        .new6        (new_v[5]),
        .rec_valid   (rec_valid),
        .rec_left    (rec_left),
        .rec_right   (rec_right),
        .rec_parent  (rec_parent),
        .rec_weight  (rec_weight),
        .root        (root),
        .merge_over  (merge_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_rec(input int v, input int k, input int l, input int r, input int p, input int w);
        tbl[v].l[k]  = 5'(l);
        tbl[v].r[k]  = 5'(r);
        tbl[v].p[k]  = 5'(p);
        tbl[v].rw[k] = 8'(w);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rec_valid"},  32'(rec_valid),  32'd0);
        chk({tag, " rec_left"},   32'(rec_left),   32'd0);
        chk({tag, " rec_right"},  32'(rec_right),  32'd0);
        chk({tag, " rec_parent"}, 32'(rec_parent), 32'd0);
        chk({tag, " rec_weight"}, 32'(rec_weight), 32'd0);
        chk({tag, " root"},       32'(root),       32'd0);
        chk({tag, " merge_over"}, 32'(merge_over), 32'd0);
    endtask

    // One full run: capture, then check every cycle up to 11 edges later
    task automatic run_vec(input int idx, input bit disturb, input int abort_cyc);
        int rec;
        int last;
        string tag;
        rec  = 0;
        last = -1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) new_v[k] = {tbl[idx].w[k], 5'(k)};
        merge_begin = 1'b1;
        for (int cyc = 0; cyc <= 11; cyc++) begin
            @(negedge clk);
            tag = $sformatf("v%0d d%0d c%0d", idx, disturb, cyc);
            if (cyc == 0) merge_begin = 1'b0;
            if (disturb && (cyc == 1 || cyc == 2)) begin
                merge_begin = 1'b1;
                for (int k = 0; k < 6; k++) new_v[k] = {8'd1, 5'd31};
            end
            if (disturb && cyc == 3) merge_begin = 1'b0;
            chk({tag, " rec_valid"}, 32'(rec_valid), 32'((cyc % 2 == 1) && (cyc <= 9)));
            chk({tag, " merge_over"}, 32'(merge_over), 32'(cyc >= 10));
            if (rec_valid === 1'b1 && rec < 5) begin
                chk({tag, " left"},   32'(rec_left),   32'(tbl[idx].l[rec]));
                chk({tag, " right"},  32'(rec_right),  32'(tbl[idx].r[rec]));
                chk({tag, " parent"}, 32'(rec_parent), 32'(tbl[idx].p[rec]));
                chk({tag, " weight"}, 32'(rec_weight), 32'(tbl[idx].rw[rec]));
                last = rec;
                rec++;
            end else if (last >= 0) begin
                chk({tag, " hold parent"}, 32'(rec_parent), 32'(tbl[idx].p[last]));
                chk({tag, " hold weight"}, 32'(rec_weight), 32'(tbl[idx].rw[last]));
            end
            if (cyc == 10) chk({tag, " root"}, 32'(root), 32'(tbl[idx].root));
            if (cyc == abort_cyc) begin
                nrst = 1'b0;
                #1;
                chk_all_zero({tag, " abort"});
                @(negedge clk);
                nrst = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    chk($sformatf("post reset idle%0d rec_valid", j), 32'(rec_valid), 32'd0);
                    chk($sformatf("post reset idle%0d merge_over", j), 32'(merge_over), 32'd0);
                end
                return;
            end
        end
        chk($sformatf("v%0d d%0d record count", idx, disturb), 32'(rec), 32'd5);
    endtask

    initial begin
        // Vector 0: weights 1..6
        for (int k = 0; k < 6; k++) tbl[0].w[k] = 8'(k + 1);
        set_rec(0, 0, 0, 1, 6, 3);
        set_rec(0, 1, 6, 2, 7, 6);
        set_rec(0, 2, 3, 4, 8, 9);
        set_rec(0, 3, 7, 5, 9, 12);
        set_rec(0, 4, 8, 9, 10, 21);
        tbl[0].root = 13'h2AA;
        // Vector 1: all equal weights, parent goes before equal entries
        for (int k = 0; k < 6; k++) tbl[1].w[k] = 8'd4;
        set_rec(1, 0, 0, 1, 6, 8);
        set_rec(1, 1, 2, 3, 7, 8);
        set_rec(1, 2, 4, 5, 8, 8);
        set_rec(1, 3, 8, 7, 9, 16);
        set_rec(1, 4, 6, 9, 10, 24);
        tbl[1].root = {8'd24, 5'd10};
        // Vector 2: saturating sums
        for (int k = 0; k < 6; k++) tbl[2].w[k] = 8'd200;
        set_rec(2, 0, 0, 1, 6, 255);
        set_rec(2, 1, 2, 3, 7, 255);
        set_rec(2, 2, 4, 5, 8, 255);
        set_rec(2, 3, 8, 7, 9, 255);
        set_rec(2, 4, 9, 6, 10, 255);
        tbl[2].root = 13'h1FEA;

        nrst        = 1'b0;
        merge_begin = 1'b0;
        for (int k = 0; k < 6; k++) new_v[k] = 13'd0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        nrst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("idle%0d rec_valid", j), 32'(rec_valid), 32'd0);
        end

        for (int v = 0; v < 3; v++) run_vec(v, 1'b0, -1);
        run_vec(0, 1'b1, -1);
        run_vec(1, 1'b1, -1);
        run_vec(0, 1'b0, 3);
        run_vec(0, 1'b0, -1);
        run_vec(2, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
